instruction_queue: RTL and testbench
====================================

Name: instruction_queue

Overview:
- Parametrised successor to the single-entry instruction register: a DEPTH-entry, WIDTH-bit instruction queue between instruction memory fetch and decode.
- Fetch writes words with IRWRITE. Decode reads the head word, which is always presented (show-ahead), and consumes it with pop.
- Adds flush (branch/jump redirect), full/empty status, occupancy count and a sticky overflow flag. The single-entry register had none of these.

Parameters:
- WIDTH, 32: instruction word width in bits.
- DEPTH, 4: number of entries; must be a power of two and >= 2.
- ADDR_W, log2(DEPTH): pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- instructionIn  input  WIDTH  word to enqueue.
- IRWRITE  input  1  enqueue request for instructionIn.
- pop  input  1  dequeue request from decode.
- flush  input  1  discard all entries.
- instruction  output  WIDTH  head entry; 0 when the queue is empty.
- valid  output  1  queue non-empty.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when an IRWRITE is dropped.

Behaviour:
- Storage: DEPTH x WIDTH register array, write pointer wr_ptr, read pointer rd_ptr (ADDR_W bits each), count register. Pointers wrap modulo DEPTH naturally (DEPTH-1 -> 0).
- Reset (asynchronous, any time, including mid-operation): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Array contents are don't-care. Outputs immediately read instruction=0, valid=0, full=0, count=0.
- Outputs are combinational from state:
  - valid = (count != 0)
  - full = (count == DEPTH)
  - instruction = valid ? mem[rd_ptr] : 0
- Per rising edge, evaluated in priority order:
  1. flush=1: wr_ptr=0, rd_ptr=0, count=0, overflow=0. IRWRITE and pop in the same cycle are ignored; nothing is written.
  2. Otherwise, pop_ok = pop & valid. A pop on an empty queue is ignored, with no error.
  3. push_ok = IRWRITE & (~full | pop_ok). On a full queue with a simultaneous accepted pop, the push is accepted.
  4. push_ok: mem[wr_ptr] <= instructionIn; wr_ptr += 1.
  5. pop_ok: rd_ptr += 1.
  6. count updates as +1 (push only), -1 (pop only), or unchanged (both or neither).
  7. IRWRITE & ~push_ok: word dropped, overflow <= 1. overflow clears only on flush or reset.
- Latency:
  - A word written at edge N is visible on instruction after edge N when the queue was empty (one cycle write-to-head).
  - A pop at edge N exposes the next entry after edge N.
- Simultaneous push and pop on an empty queue: the pop is ignored, the push is accepted, count becomes 1.
- Simultaneous push and pop with count=1: the head is replaced by the new word after the edge; count stays 1.
- Count never exceeds DEPTH and never underflows below 0.

Test Plan:
- Reset/idle: assert reset asynchronously mid-cycle with count=3 -> instruction=0, valid=0, count=0, full=0, overflow=0 before the next clk edge.
- Fill and drain (DEPTH=4): push 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> full=1, count=4. Then pop 4 times -> instruction sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444, then valid=0, instruction=0.
- Overflow: with full=1, push 0xDEADBEEF without pop -> count=4, overflow=1, head unchanged. Drain -> 0xDEADBEEF never appears.
- Full with simultaneous push/pop: with full=1, push 0x55555555 with pop -> count=4, head advances. After 3 further pops the head is 0x55555555; overflow stays 0.
- Wrap-around: run 10 push/pop pairs interleaved with count between 1 and 3 -> output order matches input order across pointer wrap; count is correct every cycle.
- Flush priority: with count=3, assert flush together with IRWRITE (0x66666666) and pop -> next cycle count=0, valid=0, overflow=0. A following push of 0x77777777 -> instruction=0x77777777, count=1.

Source files
------------

// File: rtl/instruction_queue_if.sv
// rtl/instruction_queue_if.sv - fetch/decode side bundle for the instruction queue
//
// Purpose: groups the enqueue, dequeue, flush and status signals of
// instruction_queue so fetch/decode logic and the queue share one port.
// Ports (signals):
//   instructionIn [WIDTH]    word to enqueue
//   IRWRITE                  enqueue request
//   pop                      dequeue request from decode
//   flush                    discard all entries
//   instruction   [WIDTH]    head entry (0 when empty)
//   valid                    queue non-empty
//   full                     occupancy == DEPTH
//   count         [ADDR_W+1] occupancy 0..DEPTH
//   overflow                 sticky dropped-write flag
// Modports: master = fetch/decode side, slave = the queue.

interface instruction_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] instructionIn;
    logic             IRWRITE;
    logic             pop;
    logic             flush;
    logic [WIDTH-1:0] instruction;
    logic             valid;
    logic             full;
    logic [ADDR_W:0]  count;
    logic             overflow;

    modport master (
        output instructionIn, IRWRITE, pop, flush,
        input  instruction, valid, full, count, overflow
    );

    modport slave (
        input  instructionIn, IRWRITE, pop, flush,
        output instruction, valid, full, count, overflow
    );
endinterface

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - DEPTH-entry show-ahead instruction queue between fetch and decode
//
// Purpose: circular buffer of DEPTH x WIDTH instruction words. Fetch
// enqueues with IRWRITE, decode sees the head combinationally and consumes
// it with pop. flush discards everything (branch/jump redirect) and has
// priority over push/pop. A push on a full queue is accepted only when a
// pop is accepted in the same cycle; otherwise it is dropped and the sticky
// overflow flag is set until flush or reset.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   q      instruction_queue_if.slave (instructionIn, IRWRITE, pop, flush in;
//          instruction, valid, full, count, overflow out)

module instruction_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_queue_if.slave   q
);
    localparam int              ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              ovf;

    logic is_valid;
    logic is_full;
    logic pop_ok;
    logic push_ok;

    assign is_valid = (cnt != '0);
    assign is_full  = (cnt == DEPTH_C);

    // A full queue can still take a word when the head leaves in the same cycle.
    assign pop_ok  = q.pop & is_valid & ~q.flush;
    assign push_ok = q.IRWRITE & (~is_full | pop_ok) & ~q.flush;

    assign q.valid       = is_valid;
    assign q.full        = is_full;
    assign q.count       = cnt;
    assign q.overflow    = ovf;
    assign q.instruction = is_valid ? mem[rd_ptr] : '0;

    // Array contents need no reset: nothing is visible while count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= q.instructionIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            // Pointers are exactly ADDR_W bits, so DEPTH-1 wraps to 0 for free.
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
                default: cnt <= cnt;
            endcase
            if (q.IRWRITE && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - self-checking bench for instruction_queue

module tb_instruction_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    instruction_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) q ();

    instruction_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {instruction, valid, full, count, overflow}
    logic [37:0] obs;
    assign obs = {q.instruction, q.valid, q.full, q.count, q.overflow};

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: a plain FIFO of words plus a sticky overflow bit.
    logic [31:0] mq[$];
    bit          movf;

    function automatic logic [37:0] model_state();
        logic [31:0] h;
        int          n;
        n = mq.size();
        h = (n != 0) ? mq[0] : 32'h0;
        return {h, (n != 0), (n == DEPTH), 3'(n), movf};
    endfunction

    function automatic void model_apply(input bit w, input logic [31:0] d,
                                        input bit p, input bit f);
        bit was_full;
        bit pop_ok;
        bit push_ok;
        if (f) begin
            mq.delete();
            movf = 1'b0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        pop_ok   = p && (mq.size() != 0);
        push_ok  = w && (!was_full || pop_ok);
        if (pop_ok)  void'(mq.pop_front());
        if (push_ok) mq.push_back(d);
        if (w && !push_ok) movf = 1'b1;
    endfunction

    // Drive one cycle of inputs at the falling edge, update the model at the
    // rising edge, and return 1 time unit later, ready for sampling.
    task automatic step(input bit w, input logic [31:0] d, input bit p, input bit f);
        @(negedge clk);
        q.IRWRITE       = w;
        q.instructionIn = d;
        q.pop           = p;
        q.flush         = f;
        @(posedge clk);
        model_apply(w, d, p, f);
        #1;
    endtask

    task automatic idle_inputs();
        q.IRWRITE       = 1'b0;
        q.instructionIn = '0;
        q.pop           = 1'b0;
        q.flush         = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #12;
        total_cnt++;
        if (obs !== 38'h0) $display("FAIL reset_initial: got %h want %h", obs, 38'h0);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        movf = 1'b0;
        step(1, 32'hA0000001, 0, 0);
        step(1, 32'hA0000002, 0, 0);
        step(1, 32'hA0000003, 0, 0);
        total_cnt++;
        if (obs !== model_state()) $display("FAIL reset_prefill: got %h want %h", obs, model_state());
        else pass_cnt++;
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        mq.delete();
        movf = 1'b0;
        total_cnt++;
        if (obs !== 38'h0) $display("FAIL reset_async_midcycle: got %h want %h", obs, 38'h0);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_words [4];
        exp_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, exp_words[i], 0, 0);
        total_cnt++;
        if (!(q.full === 1'b1 && q.count === 3'd4 && q.instruction === 32'h11111111))
            $display("FAIL fill_full: full=%b count=%0d head=%h want full=1 count=4 head=11111111",
                     q.full, q.count, q.instruction);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (q.instruction !== exp_words[i])
                $display("FAIL drain_head_%0d: got %h want %h", i, q.instruction, exp_words[i]);
            else pass_cnt++;
            step(0, 0, 1, 0);
        end
        total_cnt++;
        if (obs !== 38'h0) $display("FAIL drain_empty: got %h want %h", obs, 38'h0);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        step(0, 0, 0, 1);
        step(1, 32'h11111111, 0, 0);
        step(1, 32'h22222222, 0, 0);
        step(1, 32'h33333333, 0, 0);
        step(1, 32'h44444444, 0, 0);
        step(1, 32'hDEADBEEF, 0, 0);
        total_cnt++;
        if (!(q.count === 3'd4 && q.overflow === 1'b1 && q.instruction === 32'h11111111))
            $display("FAIL overflow_set: count=%0d ovf=%b head=%h want count=4 ovf=1 head=11111111",
                     q.count, q.overflow, q.instruction);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (q.instruction === 32'hDEADBEEF || obs !== model_state())
                $display("FAIL overflow_drain_%0d: got %h want %h", i, obs, model_state());
            else pass_cnt++;
            step(0, 0, 1, 0);
        end
        total_cnt++;
        if (!(q.valid === 1'b0 && q.overflow === 1'b1))
            $display("FAIL overflow_sticky: valid=%b ovf=%b want valid=0 ovf=1", q.valid, q.overflow);
        else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        step(0, 0, 0, 1);
        step(1, 32'h11111111, 0, 0);
        step(1, 32'h22222222, 0, 0);
        step(1, 32'h33333333, 0, 0);
        step(1, 32'h44444444, 0, 0);
        step(1, 32'h55555555, 1, 0);
        total_cnt++;
        if (!(q.count === 3'd4 && q.instruction === 32'h22222222 && q.overflow === 1'b0))
            $display("FAIL full_pushpop: count=%0d head=%h ovf=%b want count=4 head=22222222 ovf=0",
                     q.count, q.instruction, q.overflow);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        total_cnt++;
        if (!(q.instruction === 32'h55555555 && q.count === 3'd1 && q.overflow === 1'b0))
            $display("FAIL full_pushpop_tail: head=%h count=%0d ovf=%b want head=55555555 count=1 ovf=0",
                     q.instruction, q.count, q.overflow);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit w;
        bit p;
        int pairs;
        int guard;
        step(0, 0, 0, 1);
        step(1, $urandom, 0, 0);
        pairs = 0;
        guard = 0;
        while (pairs < 10 && guard < 100) begin
            guard++;
            if (mq.size() <= 1)      begin w = 1; p = $urandom_range(0, 1); end
            else if (mq.size() >= 3) begin p = 1; w = $urandom_range(0, 1); end
            else begin w = $urandom_range(0, 1); p = $urandom_range(0, 1); end
            if (w && p) pairs++;
            step(w, $urandom, p, 0);
            total_cnt++;
            if (obs !== model_state() || q.count < 3'd1 || q.count > 3'd3)
                $display("FAIL wrap_cycle_%0d: got %h want %h", guard, obs, model_state());
            else pass_cnt++;
        end
        total_cnt++;
        if (pairs < 10) $display("FAIL wrap_pairs: got %0d want 10", pairs);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        step(0, 0, 0, 1);
        step(1, 32'hB0000001, 0, 0);
        step(1, 32'hB0000002, 0, 0);
        step(1, 32'hB0000003, 0, 0);
        step(1, 32'h66666666, 1, 1);
        total_cnt++;
        if (obs !== 38'h0) $display("FAIL flush_priority: got %h want %h", obs, 38'h0);
        else pass_cnt++;
        step(1, 32'h77777777, 0, 0);
        total_cnt++;
        if (!(q.instruction === 32'h77777777 && q.count === 3'd1 && q.valid === 1'b1))
            $display("FAIL flush_then_push: head=%h count=%0d want head=77777777 count=1",
                     q.instruction, q.count);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit w;
        bit p;
        bit f;
        for (int i = 0; i < 300; i++) begin
            w = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 40) == 0);
            step(w, $urandom, p, f);
            total_cnt++;
            if (obs !== model_state())
                $display("FAIL random_cycle_%0d: got %h want %h", i, obs, model_state());
            else pass_cnt++;
        end
    endtask

    initial begin
        idle_inputs();
        movf = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
